// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// request legality rule used at accept time.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  // Illegal size, misaligned half/word, or outside the 256-byte window.
  function automatic logic req_error(input logic [1:0] size, input logic [31:0] addr);
    logic err;
    err = (size == SZ_ILL) ||
          (size == SZ_HALF && addr[0]) ||
          (size == SZ_WORD && addr[1:0] != 2'b00) ||
          (addr[31:8] != 24'd0);
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: extracts/extends load data from a memory word and
// merges right-aligned store data into the addressed little-endian lane(s).
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;

  always_comb begin
    sh      = {offset, 3'b000};
    shifted = word >> sh;
    mask    = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        mask      = 32'h0000_00FF << sh;
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        mask      = 32'h0000_FFFF << sh;
      end
      default: load_data = word;
    endcase
    // Word stores see an all-ones mask, so the merge degenerates to wdata.
    merged = (word & ~mask) | ((wdata << sh) & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a 64x32 word memory with
// combinational read; byte/half stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [5:0]  mem_a,
  output logic [31:0] mem_d,
  input  logic [31:0] mem_q
);

  state_t      state;
  logic        we_p0;
  logic        sgn_p0;
  logic [1:0]  size_p0;
  logic [7:0]  addr_p0;
  logic [31:0] wdata_p0;
  logic [31:0] cap_p0;
  logic [31:0] lane_word;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  // In WR the lane logic merges into the word captured during RD.
  assign lane_word = (state == WR) ? cap_p0 : mem_q;

  lsu_lane u_lane (
    .size      (size_p0),
    .sign_ext  (sgn_p0),
    .offset    (addr_p0[1:0]),
    .word      (lane_word),
    .wdata     (wdata_p0),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);
  assign mem_we     = (state == WR);
  assign mem_a      = (state == RD || state == WR) ? addr_p0[7:2] : 6'd0;
  assign mem_d      = (state == WR) ? lane_merged : 32'd0;

  // Control: FSM and response registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          resp_rdata <= 32'd0;
          resp_err   <= req_error(req_size, req_addr);
          if (req_error(req_size, req_addr))
            state <= RESP;
          else if (req_we && req_size == SZ_WORD)
            state <= WR;
          else
            state <= RD;
        end
        RD: begin
          if (!we_p0) begin
            resp_rdata <= lane_load;
            state      <= RESP;
          end else begin
            state <= WR;
          end
        end
        WR:   state <= RESP;
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: request latch at accept and RMW capture in RD (data, no reset).
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      we_p0    <= req_we;
      size_p0  <= req_size;
      sgn_p0   <= req_signed;
      addr_p0  <= req_addr[7:0];
      wdata_p0 <= req_wdata;
    end
    if (state == RD) cap_p0 <= mem_q;
  end

endmodule
